// File: rtl/tia_hsync_pkg.sv
// Shared types, LFSR helpers and decode constants for the TIA horizontal sync controller.
package tia_hsync_pkg;

   typedef enum logic [1:0] {
      RESYNC,
      WAIT_LOCK,
      RUN
   } hstate_e;

   localparam int LINE_STATES = 57;
   localparam logic [5:0] BIN_WRAP = 6'd56;

   localparam int HSYNC_START_IDX = 4;
   localparam int HSYNC_END_IDX   = 8;
   localparam int HBLANK_END_IDX  = 17;

   function automatic logic [5:0] lfsr_next(input logic [5:0] v);
      return {v[4:0], ~(v[5] ^ v[4])};
   endfunction

   // Maps a count index (advances since 0) onto its LFSR encoding.
   function automatic logic [5:0] lfsr_at(input int idx);
      logic [5:0] v;
      v = '0;
      for (int i = 0; i < idx; i++) begin
         v = lfsr_next(v);
      end
      return v;
   endfunction

   localparam logic [5:0] HC_WRAP           = lfsr_at(LINE_STATES - 1);
   localparam logic [5:0] HSYNC_START_CODE  = lfsr_at(HSYNC_START_IDX);
   localparam logic [5:0] HSYNC_END_CODE    = lfsr_at(HSYNC_END_IDX);
   localparam logic [5:0] HBLANK_END_CODE   = lfsr_at(HBLANK_END_IDX);

endpackage

// File: rtl/tia_hsync_lfsr6.sv
// 6-bit horizontal counter: 57-state LFSR, or plain binary 0..56 with TIA_HSYNC_BINARY_COUNT_EN.
module tia_lfsr6
   import tia_hsync_pkg::*;
(
   input  logic       clk,
   input  logic       r,
   input  logic       clear,
   input  logic       advance,
   output logic [5:0] count_q,
   output logic [5:0] count_d,
   output logic       wrap
);

`ifdef TIA_HSYNC_BINARY_COUNT_EN
   localparam logic [5:0] WRAP_VAL = BIN_WRAP;
`else
   localparam logic [5:0] WRAP_VAL = HC_WRAP;
`endif

   always_comb begin
      wrap    = 1'b0;
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (advance) begin
         if (count_q == WRAP_VAL) begin
            wrap    = 1'b1;
            count_d = '0;
         end else begin
`ifdef TIA_HSYNC_BINARY_COUNT_EN
            count_d = count_q + 6'd1;
`else
            count_d = lfsr_next(count_q);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/tia_horizontal_sync_controller.sv
// TIA horizontal timing: resync handshake, 57-state line counter, HSYNC/HBLANK decode, WSYNC stall.
// Build option TIA_HSYNC_BINARY_COUNT_EN swaps the LFSR counter for a binary one.
module tia_horizontal_sync_controller
   import tia_hsync_pkg::*;
#(
   parameter int RSYN_CYCLES = 2,
   parameter int HSYNC_START = HSYNC_START_IDX,
   parameter int HSYNC_END   = HSYNC_END_IDX,
   parameter int HBLANK_END  = HBLANK_END_IDX
) (
   input  logic       clk,
   input  logic       r,
   input  logic       rsync_stb,
   input  logic       wsync_stb,
   input  logic       hphi1,
   input  logic       hphi2,
   input  logic       rsynl,
   output logic       rsyn,
   output logic [5:0] hcount,
   output logic       hsync,
   output logic       hblank,
   output logic       rdy,
   output logic       line_stb,
   output logic       err
);

   localparam logic [3:0] RSYN_LAST = 4'(RSYN_CYCLES - 1);

`ifndef TIA_HSYNC_BINARY_COUNT_EN
   localparam logic [5:0] HSYNC_ON_CODE  = (HSYNC_START == HSYNC_START_IDX) ?
                                           HSYNC_START_CODE : lfsr_at(HSYNC_START);
   localparam logic [5:0] HSYNC_OFF_CODE = (HSYNC_END == HSYNC_END_IDX) ?
                                           HSYNC_END_CODE : lfsr_at(HSYNC_END);
   localparam logic [5:0] HBLANK_OFF_CODE = (HBLANK_END == HBLANK_END_IDX) ?
                                            HBLANK_END_CODE : lfsr_at(HBLANK_END);
`endif

   hstate_e    state_q, state_d;
   logic       rsyn_q, rsyn_d;
   logic [3:0] rsyn_cnt_q, rsyn_cnt_d;
   logic       seen_q, seen_d;
   logic       hphi2_q, hphi2_d;
   logic       hsync_q, hsync_d;
   logic       hblank_q, hblank_d;
   logic       rdy_q, rdy_d;
   logic       line_stb_q, line_stb_d;
   logic       err_q, err_d;

   logic       advance;
   logic       wrap;
   logic [5:0] hcount_q;
   logic [5:0] hcount_d;

   // An RSYNC strobe wins over a coincident phi2 rising edge.
   assign advance = (state_q == RUN) && hphi2 && !hphi2_q && !rsync_stb;

   tia_lfsr6 u_counter (
      .clk     (clk),
      .r       (r),
      .clear   (rsync_stb),
      .advance (advance),
      .count_q (hcount_q),
      .count_d (hcount_d),
      .wrap    (wrap)
   );

   always_comb begin
      state_d    = state_q;
      rsyn_cnt_d = rsyn_cnt_q;
      seen_d     = seen_q;
      hphi2_d    = hphi2;
      err_d      = err_q | (hphi1 & hphi2);
      line_stb_d = wrap;
      rdy_d      = rdy_q;

      case (state_q)
         RESYNC: begin
            if (rsyn_cnt_q >= RSYN_LAST) begin
               state_d    = WAIT_LOCK;
               rsyn_cnt_d = '0;
            end else begin
               rsyn_cnt_d = rsyn_cnt_q + 4'd1;
            end
         end
         WAIT_LOCK: begin
            if (seen_q && !rsynl) begin
               state_d = RUN;
            end else if (rsynl) begin
               seen_d = 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = RESYNC;
         end
      endcase

      // A WSYNC landing on the wrap keeps the CPU stalled for another whole line.
      if (wsync_stb && (rdy_q || wrap)) begin
         rdy_d = 1'b0;
      end else if (wrap) begin
         rdy_d = 1'b1;
      end

      if (rsync_stb) begin
         state_d    = RESYNC;
         rsyn_cnt_d = '0;
         seen_d     = 1'b0;
         rdy_d      = 1'b1;
      end

      rsyn_d = (state_d == RESYNC);

`ifdef TIA_HSYNC_BINARY_COUNT_EN
      hsync_d  = (int'(hcount_d) >= HSYNC_START) && (int'(hcount_d) < HSYNC_END);
      hblank_d = (int'(hcount_d) < HBLANK_END);
`else
      // LFSR codes are not ordered, so the decodes toggle on the boundary codes instead.
      hsync_d  = hsync_q;
      hblank_d = hblank_q;
      if (hcount_d == 6'd0) begin
         hsync_d  = 1'b0;
         hblank_d = 1'b1;
      end
      if (hcount_d == HSYNC_ON_CODE) begin
         hsync_d = 1'b1;
      end else if (hcount_d == HSYNC_OFF_CODE) begin
         hsync_d = 1'b0;
      end
      if (hcount_d == HBLANK_OFF_CODE) begin
         hblank_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state_q    <= RESYNC;
         rsyn_q     <= 1'b1;
         rsyn_cnt_q <= '0;
         seen_q     <= 1'b0;
         hphi2_q    <= 1'b0;
         hsync_q    <= 1'b0;
         hblank_q   <= 1'b1;
         rdy_q      <= 1'b1;
         line_stb_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsyn_q     <= rsyn_d;
         rsyn_cnt_q <= rsyn_cnt_d;
         seen_q     <= seen_d;
         hphi2_q    <= hphi2_d;
         hsync_q    <= hsync_d;
         hblank_q   <= hblank_d;
         rdy_q      <= rdy_d;
         line_stb_q <= line_stb_d;
         err_q      <= err_d;
      end
   end

   assign rsyn     = rsyn_q;
   assign hcount   = hcount_q;
   assign hsync    = hsync_q;
   assign hblank   = hblank_q;
   assign rdy      = rdy_q;
   assign line_stb = line_stb_q;
   assign err      = err_q;

endmodule

// File: tb/tb_tia_horizontal_sync_controller.sv
// Scoreboard bench for tia_horizontal_sync_controller: a line-index model predicts outputs per clock.
module tb_tia_horizontal_sync_controller;

   localparam int LINE_LEN    = 57;
   localparam int HSYNC_START = 4;
   localparam int HSYNC_END   = 8;
   localparam int HBLANK_END  = 17;

   localparam int SIG_HCOUNT = 0;
   localparam int SIG_HSYNC  = 1;
   localparam int SIG_HBLANK = 2;
   localparam int SIG_RDY    = 3;
   localparam int SIG_LINE   = 4;
   localparam int SIG_RSYN   = 5;
   localparam int SIG_ERR    = 6;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       rsync_stb = 1'b0;
   logic       wsync_stb = 1'b0;
   logic       hphi1 = 1'b0;
   logic       hphi2 = 1'b0;
   logic       rsynl = 1'b0;
   logic       rsyn;
   logic [5:0] hcount;
   logic       hsync;
   logic       hblank;
   logic       rdy;
   logic       line_stb;
   logic       err;

   tia_horizontal_sync_controller dut (
      .clk       (clk),
      .r         (r),
      .rsync_stb (rsync_stb),
      .wsync_stb (wsync_stb),
      .hphi1     (hphi1),
      .hphi2     (hphi2),
      .rsynl     (rsynl),
      .rsyn      (rsyn),
      .hcount    (hcount),
      .hsync     (hsync),
      .hblank    (hblank),
      .rdy       (rdy),
      .line_stb  (line_stb),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   tbl[LINE_LEN];
   int   model_idx = 0;
   bit   model_rdy = 1'b1;
   int   hold = 0;

   function automatic string sig_name(input int sig);
      case (sig)
         SIG_HCOUNT: return "hcount";
         SIG_HSYNC:  return "hsync";
         SIG_HBLANK: return "hblank";
         SIG_RDY:    return "rdy";
         SIG_LINE:   return "line_stb";
         SIG_RSYN:   return "rsyn";
         default:    return "err";
      endcase
   endfunction

   function automatic logic [31:0] dut_val(input int sig);
      case (sig)
         SIG_HCOUNT: return {26'b0, hcount};
         SIG_HSYNC:  return {31'b0, hsync};
         SIG_HBLANK: return {31'b0, hblank};
         SIG_RDY:    return {31'b0, rdy};
         SIG_LINE:   return {31'b0, line_stb};
         SIG_RSYN:   return {31'b0, rsyn};
         default:    return {31'b0, err};
      endcase
   endfunction

   function automatic int exp_hcount(input int idx);
`ifdef TIA_HSYNC_BINARY_COUNT_EN
      return idx;
`else
      return tbl[idx];
`endif
   endfunction

   task automatic check_output(input exp_t e);
      logic [31:0] act;
      act = dut_val(e.sig);
      n_vec++;
      if (e.cyc != cyc || act !== 32'(e.val)) begin
         n_bad++;
         $display("[TB] FAIL %s @cycle %0d (due %0d): got %0d, expected %0d",
                  sig_name(e.sig), cyc, e.cyc, act, e.val);
      end
   endtask

   // Monitor: pops every expectation due at the current sample point.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_output(e);
         end
      end
   end

   // Clock generator stand-in: latches reset while rsyn is high, releases 3 cycles after.
   always @(negedge clk) begin
      if (rsyn === 1'b1) begin
         rsynl = 1'b1;
         hold  = 3;
      end else if (hold > 0) begin
         hold--;
         if (hold == 0) rsynl = 1'b0;
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push(input int at, input int sig, input int val);
      exp_t e;
      e.cyc = at;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic push_state(input int at);
      push(at, SIG_HCOUNT, exp_hcount(model_idx));
      push(at, SIG_HSYNC, (model_idx >= HSYNC_START && model_idx < HSYNC_END) ? 1 : 0);
      push(at, SIG_HBLANK, (model_idx < HBLANK_END) ? 1 : 0);
      push(at, SIG_RDY, int'(model_rdy));
   endtask

   // One hphi2 rising edge; wmode 1 puts WSYNC on the edge, 2 puts it one cycle later.
   task automatic apply_stimulus(input int gap, input int wmode);
      bit wrap;
      int at;
      @(negedge clk);
      hphi2 = 1'b1;
      at    = cyc + 1;
      wrap  = (model_idx == LINE_LEN - 1);
      model_idx = wrap ? 0 : model_idx + 1;
      if (wmode == 1) wsync_stb = 1'b1;
      if (wrap) model_rdy = (wmode == 1) ? 1'b0 : 1'b1;
      else if (wmode == 1) model_rdy = 1'b0;
      push_state(at);
      push(at, SIG_LINE, wrap ? 1 : 0);
      push(at, SIG_ERR, 0);
      if (wrap) push(at + 1, SIG_LINE, 0);
      @(negedge clk);
      hphi2     = 1'b0;
      wsync_stb = 1'b0;
      if (wmode == 2) begin
         wsync_stb = 1'b1;
         model_rdy = 1'b0;
         push(cyc + 1, SIG_RDY, 0);
      end
      for (int i = 2; i < gap; i++) begin
         @(negedge clk);
         wsync_stb = 1'b0;
      end
   endtask

   task automatic do_rsync(input bit with_edge, input int n_stb);
      int at;
      @(negedge clk);
      rsync_stb = 1'b1;
      if (with_edge) hphi2 = 1'b1;
      at        = cyc + 1;
      model_idx = 0;
      model_rdy = 1'b1;
      push_state(at);
      push(at, SIG_LINE, 0);
      push(at, SIG_RSYN, 1);
      for (int k = 1; k < n_stb; k++) begin
         @(negedge clk);
         hphi2 = 1'b0;
         push(cyc + 1, SIG_RSYN, 1);
      end
      @(negedge clk);
      rsync_stb = 1'b0;
      hphi2     = 1'b0;
      push(cyc + 1, SIG_RSYN, 1);
      push(cyc + 1, SIG_HCOUNT, 0);
      @(negedge clk);
      push(cyc + 1, SIG_RSYN, 0);
      push(cyc + 1, SIG_HCOUNT, 0);
      repeat (12) @(negedge clk);
   endtask

   initial begin : stimulus
      int v;
      int wpos;
      v = 0;
      for (int i = 0; i < LINE_LEN; i++) begin
         tbl[i] = v;
         v = ((v << 1) & 63) | ((~((v >> 5) ^ (v >> 4))) & 1);
      end

      for (int c = 1; c <= 2; c++) begin
         push(c, SIG_HCOUNT, 0);
         push(c, SIG_HSYNC, 0);
         push(c, SIG_HBLANK, 1);
         push(c, SIG_RDY, 1);
         push(c, SIG_LINE, 0);
         push(c, SIG_ERR, 0);
         push(c, SIG_RSYN, 1);
      end
      repeat (2) @(negedge clk);
      r = 1'b0;
      push(cyc + 1, SIG_RSYN, 1);
      push(cyc + 2, SIG_RSYN, 0);
      repeat (2) @(negedge clk);
      hphi2 = 1'b1;
      push(cyc + 1, SIG_HCOUNT, 0);
      @(negedge clk);
      hphi2 = 1'b0;
      push(cyc + 1, SIG_HCOUNT, 0);
      push(cyc + 1, SIG_HBLANK, 1);
      push(cyc + 1, SIG_RDY, 1);
      repeat (8) @(negedge clk);

      $display("[TB] line 1: full line, WSYNC at index 20");
      for (int i = 0; i < LINE_LEN; i++) begin
         apply_stimulus((i < 8) ? 4 : int'($urandom_range(3, 6)),
                        (i == 19 || i == 40) ? 2 : 0);
      end

      $display("[TB] line 2: RSYNC at index 30 with CPU stalled");
      wpos = int'($urandom_range(5, 25));
      for (int i = 0; i < 30; i++) begin
         apply_stimulus(int'($urandom_range(3, 6)), (i == wpos) ? 2 : 0);
      end
      do_rsync(1'b1, 1);

      $display("[TB] line 3/4: WSYNC on the wrap edge");
      for (int i = 0; i < LINE_LEN; i++) begin
         apply_stimulus(int'($urandom_range(3, 6)), (i == LINE_LEN - 1) ? 1 : 0);
      end
      for (int i = 0; i < LINE_LEN; i++) begin
         apply_stimulus(int'($urandom_range(3, 6)), 0);
      end

      $display("[TB] back-to-back RSYNC and phase overlap");
      do_rsync(1'b0, 2);
      @(negedge clk);
      hphi1 = 1'b1;
      hphi2 = 1'b1;
      push(cyc + 1, SIG_ERR, 1);
      @(negedge clk);
      hphi1 = 1'b0;
      hphi2 = 1'b0;
      for (int k = 1; k <= 4; k++) push(cyc + 2 * k, SIG_ERR, 1);
      repeat (9) @(negedge clk);

      r = 1'b1;
      push(cyc + 1, SIG_ERR, 0);
      push(cyc + 1, SIG_HCOUNT, 0);
      push(cyc + 1, SIG_RDY, 1);
      push(cyc + 1, SIG_RSYN, 1);
      push(cyc + 1, SIG_HBLANK, 1);
      push(cyc + 1, SIG_LINE, 0);
      @(negedge clk);
      r = 1'b0;
      repeat (4) @(negedge clk);

      while (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("[TB] FAIL %s: got no sample, expected check at cycle %0d",
                  sig_name(sb[0].sig), sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
